// File: rtl/pio_edge_irq.sv
// Avalon-MM parallel I/O port with synchronised inputs, edge capture and interrupt.
// Optional per-bit input debounce is enabled by defining PIO_DEBOUNCE_EN.
module pio_edge_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 0,
  parameter int DEB_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_OUT  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] s, f, edge_det;
  logic [WIDTH-1:0] f_prev_q, f_prev_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rd_q, rd_d;
  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic             cfg_unused;

  assign wr         = chipselect & ~write_n;
  assign wdata      = writedata[WIDTH-1:0];
  assign s          = sync_q[SYNC_STAGES-1];
  assign cfg_unused = ^{writedata, 8'(DEB_CYCLES)};

`ifdef PIO_DEBOUNCE_EN
  logic [WIDTH-1:0] f_q, f_d;
  logic [7:0]       cnt_q [WIDTH];
  logic [7:0]       cnt_d [WIDTH];

  // Counter runs only while s disagrees with f; any agreement restarts it.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != f_q[i]) begin
        if (cnt_q[i] == 8'(DEB_CYCLES - 1)) f_d[i] = s[i];
        else                                cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      f_q <= f_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign f = f_q;
`else
  assign f = s;
`endif

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_det = f & ~f_prev_q;
      2:       edge_det = ~f & f_prev_q;
      default: edge_det = f ^ f_prev_q;
    endcase
  end

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    f_prev_d = f;

    // A new edge overrides a simultaneous write-one-to-clear.
    edge_d = edge_q;
    if (wr && address == ADDR_EDGE) edge_d = edge_q & ~wdata;
    edge_d = edge_d | edge_det;

    mask_d = mask_q;
    if (wr && address == ADDR_MASK) mask_d = wdata;

    out_d = out_q;
    if (wr) begin
      case (address)
        ADDR_DATA: out_d = wdata;
        ADDR_SET:  out_d = out_q | wdata;
        ADDR_CLR:  out_d = out_q & ~wdata;
        default:   out_d = out_q;
      endcase
    end

    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d[WIDTH-1:0] = f;
      ADDR_OUT:  rd_d[WIDTH-1:0] = out_q;
      ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_d[WIDTH-1:0] = edge_q;
      default:   rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      f_prev_q <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      out_q    <= '0;
      rd_q     <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      f_prev_q <= f_prev_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      out_q    <= out_d;
      rd_q     <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign out_port = out_q;
  assign irq      = (IRQ_MODE == 1) ? |(f & mask_q) : |(edge_q & mask_q);

endmodule
